// File: rtl/reg_bank_seq.sv
// reg_bank_seq: request-driven sequencer that reads two bank registers, computes a result and writes it back.
module reg_bank_seq #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_sr1,
    input  logic [ADDR_W-1:0] req_sr2,
    input  logic [ADDR_W-1:0] req_dr,
    input  logic [WIDTH-1:0]  req_imm,
    output logic [ADDR_W-1:0] Sr1,
    output logic [ADDR_W-1:0] Sr2,
    input  logic [WIDTH-1:0]  rdData1,
    input  logic [WIDTH-1:0]  rdData2,
    output logic [ADDR_W-1:0] dr,
    output logic [WIDTH-1:0]  wrData,
    output logic              write,
    output logic              rsp_valid,
    output logic [WIDTH-1:0]  rsp_data,
    output logic              rsp_carry
);
    localparam int SH_W = $clog2(WIDTH);
    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                           OP_XOR = 3'd4, OP_MOVI = 3'd5, OP_READ = 3'd6;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
    state_t state, state_nx;

    logic [2:0]        op_q;
    logic [ADDR_W-1:0] sr1_q, sr2_q, dr_q;
    logic [WIDTH-1:0]  imm_q, a, b, res, res_nx, rsp_hold;
    logic [WIDTH:0]    sum;
    logic              carry, carry_nx, carry_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE ? (req_valid ? READ : IDLE) :
                   state == READ ? EXEC :
                   state == EXEC ? WB : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            sr1_q      <= '0;
            sr2_q      <= '0;
            dr_q       <= '0;
            imm_q      <= '0;
            a          <= '0;
            b          <= '0;
            res        <= '0;
            carry      <= 1'b0;
            rsp_hold   <= '0;
            carry_hold <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                op_q  <= req_op;
                sr1_q <= req_sr1;
                sr2_q <= req_sr2;
                dr_q  <= req_dr;
                imm_q <= req_imm;
            end
            if (state == READ) begin
                a <= rdData1;
                b <= rdData2;
            end
            if (state == EXEC) begin
                res   <= res_nx;
                carry <= carry_nx;
            end
            if (state == WB) begin
                rsp_hold   <= res;
                carry_hold <= carry;
            end
        end
    end

    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
        res_nx = op_q == OP_ADD  ? sum[WIDTH-1:0] :
                 op_q == OP_SUB  ? a - b :
                 op_q == OP_AND  ? a & b :
                 op_q == OP_OR   ? a | b :
                 op_q == OP_XOR  ? a ^ b :
                 op_q == OP_MOVI ? imm_q :
                 op_q == OP_READ ? a : a << b[SH_W-1:0];
        // SUB carry is the borrow out, i.e. unsigned A < B
        carry_nx = op_q == OP_ADD ? sum[WIDTH] : op_q == OP_SUB ? (a < b) : 1'b0;
    end

    assign req_ready = state == IDLE;
    assign Sr1       = sr1_q;
    assign Sr2       = sr2_q;
    assign dr        = dr_q;
    assign wrData    = res;
    assign rsp_valid = state == WB;
    assign write     = rsp_valid && op_q != OP_READ;
    assign rsp_data  = rsp_valid ? res : rsp_hold;
    assign rsp_carry = rsp_valid ? carry : carry_hold;
endmodule

// File: tb/tb_reg_bank_seq.sv
// tb_reg_bank_seq: drives reg_bank_seq against a modelled 4x32 bank and checks it against a transaction-level model.
module tb_reg_bank_seq;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [2:0]  req_op = '0;
    logic [1:0]  req_sr1 = '0, req_sr2 = '0, req_dr = '0;
    logic [31:0] req_imm = '0;
    logic [1:0]  Sr1, Sr2, dr;
    logic [31:0] rdData1, rdData2, wrData, rsp_data;
    logic        write, rsp_valid, rsp_carry;

    logic [31:0] bank [4] = '{default: 32'h0};
    logic [31:0] mreg [4] = '{default: 32'h0};
    int checks = 0, failures = 0, rsp_cnt = 0, t = 0;

    reg_bank_seq #(.WIDTH(32), .ADDR_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_sr1(req_sr1), .req_sr2(req_sr2), .req_dr(req_dr), .req_imm(req_imm),
        .Sr1(Sr1), .Sr2(Sr2), .rdData1(rdData1), .rdData2(rdData2), .dr(dr), .wrData(wrData),
        .write(write), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_carry(rsp_carry)
    );

    always #5 clk = ~clk;
    assign rdData1 = bank[Sr1];
    assign rdData2 = bank[Sr2];
    always @(posedge clk) if (write) bank[dr] <= wrData;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        failures++;
        $display("FAIL %s timed out at %0t", nm, $time);
    endtask

    // Architectural meaning of each op code, in plain wide arithmetic
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] imm, output logic [31:0] r, output logic c);
        longint unsigned la = a, lb = b;
        c = 1'b0;
        case (op)
            3'd0: begin r = 32'(la + lb); c = (la + lb) > 64'hFFFF_FFFF; end
            3'd1: begin r = 32'(la - lb); c = la < lb; end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = imm;
            3'd6: r = a;
            default: r = 32'(la << (lb % 32));
        endcase
    endfunction

    logic        pending = 1'b0, exp_wr, exp_c, last_c = 1'b0, rdy;
    logic [31:0] exp_d, last_d = '0;
    logic [1:0]  exp_dr, exp_s1, exp_s2;
    int          due = 0;

    always @(negedge clk) begin
        t++;
        if (rsp_valid) rsp_cnt++;
        if (!rst_n) begin
            chk("rst_write", write, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_rsp_carry", rsp_carry, 0);
            chk("rst_ready", req_ready, 1);
            chk("rst_sel", {Sr1, Sr2, dr}, 0);
            chk("rst_wrdata", wrData, 0);
            pending = 1'b0;
            last_d = '0;
            last_c = 1'b0;
        end else begin
            rdy = !pending;
            chk("req_ready", req_ready, rdy);
            if (pending && t == due - 2) chk("read_sel", {Sr1, Sr2}, {exp_s1, exp_s2});
            if (pending && t == due) begin
                chk("wb_rsp_valid", rsp_valid, 1);
                chk("wb_rsp_data", rsp_data, exp_d);
                chk("wb_rsp_carry", rsp_carry, exp_c);
                chk("wb_write", write, exp_wr);
                if (exp_wr) begin
                    chk("wb_dr", dr, exp_dr);
                    chk("wb_wrdata", wrData, exp_d);
                    mreg[exp_dr] = exp_d;
                end
                last_d = exp_d;
                last_c = exp_c;
                pending = 1'b0;
            end else begin
                chk("idle_rsp_valid", rsp_valid, 0);
                chk("idle_write", write, 0);
                chk("held_rsp_data", rsp_data, last_d);
                chk("held_rsp_carry", rsp_carry, last_c);
            end
            if (req_valid && rdy) begin
                model(req_op, mreg[req_sr1], mreg[req_sr2], req_imm, exp_d, exp_c);
                exp_wr = req_op != 3'd6;
                exp_dr = req_dr;
                exp_s1 = req_sr1;
                exp_s2 = req_sr2;
                due = t + 3;
                pending = 1'b1;
            end
        end
    end

    task automatic set_req(input logic [2:0] op, input logic [1:0] s1, input logic [1:0] s2,
                           input logic [1:0] d, input logic [31:0] imm);
        req_op = op; req_sr1 = s1; req_sr2 = s2; req_dr = d; req_imm = imm;
    endtask

    task automatic wait_ready(output time tt);
        int n = 0;
        do @(negedge clk); while (!req_ready && ++n < 20);
        if (!req_ready) timeout("wait_ready");
        tt = $time;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [1:0] s1, input logic [1:0] s2,
                         input logic [1:0] d, input logic [31:0] imm,
                         output logic [31:0] rd, output logic rc);
        int n = 0;
        time tt;
        set_req(op, s1, s2, d, imm);
        req_valid = 1'b1;
        wait_ready(tt);
        @(posedge clk); #1;
        req_valid = 1'b0;
        set_req(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), $urandom);
        do @(negedge clk); while (!rsp_valid && ++n < 20);
        if (!rsp_valid) timeout("wait_rsp");
        rd = rsp_data;
        rc = rsp_carry;
        @(posedge clk); #1;
    endtask

    logic [31:0] d;
    logic        c;
    time         t0, t1;
    int          cnt0;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        do_op(3'd5, 0, 0, 1, 32'd5, d, c);  chk("movi_r1", d, 32'd5);
        do_op(3'd5, 0, 0, 2, 32'd3, d, c);  chk("movi_r2", d, 32'd3);
        do_op(3'd0, 1, 2, 3, 0, d, c);
        chk("add_data", d, 32'd8); chk("add_carry", c, 0); chk("add_bank_r3", bank[3], 32'd8);
        do_op(3'd5, 0, 0, 2, 32'd3, d, c);
        do_op(3'd5, 0, 0, 1, 32'd5, d, c);
        do_op(3'd1, 2, 1, 0, 0, d, c);
        chk("sub_data", d, 32'hFFFF_FFFE); chk("sub_borrow", c, 1); chk("sub_bank_r0", bank[0], 32'hFFFF_FFFE);
        do_op(3'd6, 3, 0, 1, 0, d, c);
        chk("read_data", d, 32'd8); chk("read_no_write_r1", bank[1], 32'd5);
        do_op(3'd5, 0, 0, 1, 32'hFFFF_FFFF, d, c);
        do_op(3'd5, 0, 0, 2, 32'd1, d, c);
        do_op(3'd0, 1, 2, 3, 0, d, c);
        chk("add_ovf_data", d, 0); chk("add_ovf_carry", c, 1);
        do_op(3'd5, 0, 0, 1, 32'd1, d, c);
        do_op(3'd5, 0, 0, 2, 32'd31, d, c);
        do_op(3'd7, 1, 2, 0, 0, d, c);      chk("shl_31", d, 32'h8000_0000);
        do_op(3'd5, 0, 0, 2, 32'd33, d, c);
        do_op(3'd7, 1, 2, 0, 0, d, c);      chk("shl_33", d, 32'h2);
        do_op(3'd5, 0, 0, 1, 32'd5, d, c);
        do_op(3'd5, 0, 0, 2, 32'd3, d, c);
        do_op(3'd0, 1, 2, 1, 0, d, c);      chk("add_src_eq_dst", bank[1], 32'd8);
        // abort an ADD while it sits in EXEC
        do_op(3'd5, 0, 0, 2, 32'd77, d, c);
        set_req(3'd0, 1, 2, 2, 0);
        req_valid = 1'b1;
        wait_ready(t0);
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        #1 chk("abort_write", write, 0); chk("abort_rsp_valid", rsp_valid, 0); chk("abort_rsp_data", rsp_data, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("abort_r2_kept", bank[2], 32'd77);
        do_op(3'd0, 1, 2, 3, 0, d, c);      chk("after_abort_add", bank[3], 32'd85);
        // back-to-back requests with req_valid held high
        cnt0 = rsp_cnt;
        set_req(3'd5, 0, 0, 0, 32'h11);
        req_valid = 1'b1;
        wait_ready(t0);
        @(posedge clk); #1 set_req(3'd5, 0, 0, 1, 32'h22);
        wait_ready(t1);
        chk("burst_gap1", 32'(t1 - t0), 32'd40);
        @(posedge clk); #1 set_req(3'd0, 0, 1, 2, 0);
        wait_ready(t0);
        chk("burst_gap2", 32'(t0 - t1), 32'd40);
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 chk("burst_rsp_count", rsp_cnt - cnt0, 3);
        chk("burst_r2", bank[2], 32'h33);
        repeat (400) begin
            @(posedge clk); #1;
            req_valid = $urandom_range(0, 3) != 0;
            set_req(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                    $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40)));
            if ($urandom_range(0, 79) == 0) begin
                rst_n = 1'b0;
                @(posedge clk); #1 rst_n = 1'b1;
            end
        end
        req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) chk($sformatf("final_r%0d", i), bank[i], mreg[i]);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
